verifier_compute_chi_multi: RTL and testbench

//  Multi-lane successor to the single-lane chi engine. Fills chi_out[i] = scale * prod_j
//  (i[j] ? tau[j] : 1 - tau[j]) mod q for all 2^nValBits indices, using nLanes parallel

---
 rtl/verifier_compute_chi_multi.sv | 226 ++++++++++++++++++++++
 tb/tb_verifier_compute_chi_multi.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/verifier_compute_chi_multi.sv
// Multi-lane chi table engine: chi_out[i] = scale * prod_j (i[j] ? tau[j] : 1 - tau[j]) mod q.
// Each lane is a bit-serial interleaved modular multiplier producing v*tau[b] and v*(1-tau[b]).

module verifier_chi_lane #(
    parameter int           W = 16,
    parameter logic [W-1:0] Q = W'(65521)
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         en,
    input  logic [W-1:0] v,
    input  logic [W-1:0] t,
    input  logic [W-1:0] m,
    output logic         ready,
    output logic [W-1:0] p_hi,
    output logic [W-1:0] p_lo
);
    localparam int CW = $clog2(W + 1);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [W-1:0]  v_r, t_r, m_r, acc_hi, acc_lo;

    // acc < q and a < q keep every intermediate below 2q, so one conditional subtract suffices.
    function automatic logic [W-1:0] mac_step(input logic [W-1:0] acc, input logic add,
                                              input logic [W-1:0] a);
        logic [W:0] s;
        s = {acc, 1'b0};
        if (s >= {1'b0, Q}) s = s - {1'b0, Q};
        if (add) s = s + {1'b0, a};
        if (s >= {1'b0, Q}) s = s - {1'b0, Q};
        return s[W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rstb) begin
            busy <= 1'b0;
        end else if (en && !busy) begin
            busy <= 1'b1;
        end else if (busy && cnt == '0) begin
            busy <= 1'b0;
        end
    end

    // NOTE: pure datapath registers carry no reset; busy alone decides when they matter.
    always_ff @(posedge clk) begin
        if (en && !busy) begin
            cnt    <= CW'(W - 1);
            v_r    <= v;
            t_r    <= t;
            m_r    <= m;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (busy) begin
            acc_hi <= mac_step(acc_hi, v_r[W-1], t_r);
            acc_lo <= mac_step(acc_lo, v_r[W-1], m_r);
            v_r    <= {v_r[W-2:0], 1'b0};
            cnt    <= cnt - 1'b1;
        end
    end

    assign ready = !busy;
    assign p_hi  = acc_hi;
    assign p_lo  = acc_lo;
endmodule

module verifier_compute_chi_multi #(
    parameter int                 F_NBITS    = 16,
    parameter logic [F_NBITS-1:0] F_Q        = F_NBITS'(65521),
    parameter int                 nValBits   = 8,
    parameter int                 nEarlyBits = nValBits,
    parameter int                 nLanes     = 4,
    parameter int                 nValues    = 1 << nValBits
) (
    input  logic                              clk,
    input  logic                              rstb,
    input  logic                              en,
    input  logic                              early,
    input  logic [F_NBITS-1:0]                scale,
    input  logic [nValBits-1:0][F_NBITS-1:0]  tau,
    output logic [nValues-1:0][F_NBITS-1:0]   chi_out,
    output logic                              ready,
    output logic                              done
);
    if (nValues != (1 << nValBits)) begin : g_bad_nvalues
        $error("nValues is derived from nValBits and must not be overridden");
    end
    if (nEarlyBits < 1 || nEarlyBits > nValBits) begin : g_bad_early
        $error("nEarlyBits out of range");
    end
    if (nLanes < 1 || nLanes > nValues / 2 || (nLanes & (nLanes - 1)) != 0) begin : g_bad_lanes
        $error("nLanes must be a power of 2 in 1..nValues/2");
    end

    localparam int BW = $clog2(nValBits + 1);
    localparam int IW = nValBits;

    typedef enum logic [2:0] {IDLE, INIT, NEG_ST, NEG, MUL_ST, MUL, FIN} state_t;

    state_t                            state, state_nxt;
    logic                              en_dly, start, early_r;
    logic [nValBits-1:0][F_NBITS-1:0]  tau_r;
    logic [F_NBITS-1:0]                scale_r, m_r, tau_b;
    logic [BW-1:0]                     b_r;
    logic [IW-1:0]                     g_r;
    logic                              last_batch, all_ready;
    logic [nLanes-1:0]                 lane_act, lane_en, lane_ready;
    logic [nLanes-1:0][IW-1:0]         lo_idx, hi_idx;
    logic [nLanes-1:0][F_NBITS-1:0]    lane_v, p_hi, p_lo;

    assign start = en & ~en_dly;

    // Round b: source k sits at k*2^(b+1); its tau product goes 2^b above it.
    always_comb begin : batch_map
        int nact, rsize, k, src;
        nact       = early_r ? nEarlyBits : nValBits;
        rsize      = 1 << (nact - 1 - int'(b_r));
        last_batch = ((int'(g_r) + 1) * nLanes) >= rsize;
        all_ready  = 1'b1;
        tau_b      = tau_r[0];
        k          = 0;
        src        = 0;
        for (int j = 0; j < nValBits; j++) begin
            if (BW'(j) == b_r) tau_b = tau_r[j];
        end
        for (int l = 0; l < nLanes; l++) begin
            k           = int'(g_r) * nLanes + l;
            lane_act[l] = k < rsize;
            src         = lane_act[l] ? (k << (int'(b_r) + 1)) : 0;
            lo_idx[l]   = IW'(src);
            hi_idx[l]   = IW'(src + (1 << int'(b_r)));
            lane_v[l]   = chi_out[lo_idx[l]];
            if (lane_act[l] && !lane_ready[l]) all_ready = 1'b0;
        end
    end

    for (genvar l = 0; l < nLanes; l++) begin : g_lane
        verifier_chi_lane #(.W(F_NBITS), .Q(F_Q)) u_lane (
            .clk   (clk),
            .rstb  (rstb),
            .en    (lane_en[l]),
            .v     (lane_v[l]),
            .t     (tau_b),
            .m     (m_r),
            .ready (lane_ready[l]),
            .p_hi  (p_hi[l]),
            .p_lo  (p_lo[l])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = INIT;
            INIT:    state_nxt = NEG_ST;
            NEG_ST:  state_nxt = NEG;
            NEG:     state_nxt = MUL_ST;
            MUL_ST:  state_nxt = MUL;
            MUL:     if (all_ready) state_nxt = !last_batch ? MUL_ST : (b_r == '0) ? FIN : NEG_ST;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready   = (state == IDLE) && !start;
        done    = (state == FIN);
        lane_en = (state == MUL_ST) ? lane_act : '0;
    end

    // NOTE: the result table is architecturally visible and must read zero after reset.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            en_dly  <= 1'b1;
            chi_out <= '0;
            early_r <= 1'b0;
            b_r     <= '0;
            g_r     <= '0;
        end else begin
            en_dly <= en;
            case (state)
                IDLE: if (start) begin
                    early_r <= early;
                    b_r     <= BW'((early ? nEarlyBits : nValBits) - 1);
                end
                INIT: begin
                    chi_out    <= '0;
                    chi_out[0] <= scale_r;
                end
                NEG_ST: g_r <= '0;
                MUL: if (all_ready) begin
                    for (int l = 0; l < nLanes; l++) begin
                        if (lane_act[l]) begin
                            chi_out[lo_idx[l]] <= p_lo[l];
                            chi_out[hi_idx[l]] <= p_hi[l];
                        end
                    end
                    if (last_batch) begin
                        g_r <= '0;
                        if (b_r != '0) b_r <= b_r - 1'b1;
                    end else begin
                        g_r <= g_r + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            tau_r   <= tau;
            scale_r <= scale;
        end
        if (state == NEG_ST) begin
            if (tau_b == '0)                 m_r <= F_NBITS'(1);
            else if (tau_b == F_NBITS'(1))   m_r <= '0;
            else                             m_r <= F_Q - tau_b + F_NBITS'(1);
        end
    end
endmodule

// File: tb/tb_verifier_compute_chi_multi.sv
// Scoreboard bench: three engines (1/2/4 lanes, 3 coordinates, 2 early) share stimulus;
// expected tables are queued at issue and popped by per-instance monitors on done.

module tb_verifier_compute_chi_multi;
    localparam int              W = 16;
    localparam longint unsigned Q = 65521;

    logic             clk = 1'b0, rstb = 1'b0, en = 1'b0, early = 1'b0;
    logic [W-1:0]     scale = '0;
    logic [2:0][W-1:0] tau = '0;
    logic [7:0][W-1:0] chi1, chi2, chi4;
    logic             ready1, ready2, ready4, done1, done2, done4;

    int n_checks = 0, n_errors = 0, n_runs = 0;
    int dc1 = 0, dc2 = 0, dc4 = 0;
    logic [127:0] sb1[$], sb2[$], sb4[$];

    always #5 clk = ~clk;

    verifier_compute_chi_multi #(.F_NBITS(W), .F_Q(16'd65521), .nValBits(3), .nEarlyBits(2), .nLanes(1)) dut1 (
        .clk(clk), .rstb(rstb), .en(en), .early(early), .scale(scale), .tau(tau),
        .chi_out(chi1), .ready(ready1), .done(done1));
    verifier_compute_chi_multi #(.F_NBITS(W), .F_Q(16'd65521), .nValBits(3), .nEarlyBits(2), .nLanes(2)) dut2 (
        .clk(clk), .rstb(rstb), .en(en), .early(early), .scale(scale), .tau(tau),
        .chi_out(chi2), .ready(ready2), .done(done2));
    verifier_compute_chi_multi #(.F_NBITS(W), .F_Q(16'd65521), .nValBits(3), .nEarlyBits(2), .nLanes(4)) dut4 (
        .clk(clk), .rstb(rstb), .en(en), .early(early), .scale(scale), .tau(tau),
        .chi_out(chi4), .ready(ready4), .done(done4));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Direct product formula, independent of the in-place doubling schedule.
    function automatic logic [127:0] model(input logic e, input logic [W-1:0] s,
                                           input logic [2:0][W-1:0] t);
        logic [7:0][W-1:0] r;
        longint unsigned   v, f;
        int                nact;
        nact = e ? 2 : 3;
        r    = '0;
        for (int i = 0; i < (1 << nact); i++) begin
            v = s;
            for (int j = 0; j < nact; j++) begin
                f = i[j] ? longint'(t[j]) : (Q + 1 - longint'(t[j])) % Q;
                v = (v * f) % Q;
            end
            r[i] = W'(v);
        end
        return r;
    endfunction

    always @(negedge clk) if (rstb && done1) begin
        dc1++;
        check("lanes1 run pending at done", sb1.size() != 0, 1);
        if (sb1.size() != 0) check("lanes1 table", chi1, sb1.pop_front());
    end
    always @(negedge clk) if (rstb && done2) begin
        dc2++;
        check("lanes2 run pending at done", sb2.size() != 0, 1);
        if (sb2.size() != 0) check("lanes2 table", chi2, sb2.pop_front());
    end
    always @(negedge clk) if (rstb && done4) begin
        dc4++;
        check("lanes4 run pending at done", sb4.size() != 0, 1);
        if (sb4.size() != 0) check("lanes4 table", chi4, sb4.pop_front());
    end

    task automatic push(input logic [127:0] e);
        sb1.push_back(e);
        sb2.push_back(e);
        sb4.push_back(e);
        n_runs++;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while ((dc1 < n_runs || dc2 < n_runs || dc4 < n_runs) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " completes"}, cyc < 2000, 1);
        repeat (2) @(negedge clk);
        check({name, " ready after done"}, {ready1, ready2, ready4}, 3'b111);
    endtask

    task automatic run(input string name, input logic e, input logic [W-1:0] s,
                       input logic [2:0][W-1:0] t, input logic [127:0] exp);
        push(exp);
        @(negedge clk);
        early = e; scale = s; tau = t; en = 1'b1;
        #1 check({name, " ready low on start"}, {ready1, ready2, ready4}, 3'b000);
        @(negedge clk);
        en = 1'b0; scale = '1; tau = '1; early = ~e;
        wait_done(name);
    endtask

    initial begin
        logic [7:0][W-1:0] h;
        logic [2:0][W-1:0] t;
        logic [W-1:0]      s;
        logic              e;

        repeat (3) @(negedge clk);
        check("reset chi lanes1", chi1, '0);
        check("reset chi lanes2", chi2, '0);
        check("reset chi lanes4", chi4, '0);
        check("reset ready", {ready1, ready2, ready4}, 3'b111);
        check("reset done", {done1, done2, done4}, 3'b000);
        rstb = 1'b1;
        @(negedge clk);

        h = '0; h[5] = 16'd1;
        run("T1 tau 101", 1'b0, 16'd1, {16'd1, 16'd0, 16'd1}, h);

        h = {16'd8, 16'd65517, 16'd65517, 16'd2, 16'd65517, 16'd2, 16'd2, 16'd65520};
        run("T2 tau all 2", 1'b0, 16'd1, {16'd2, 16'd2, 16'd2}, h);

        h = '0; h[5] = 16'd3;
        run("T3 scale 3", 1'b0, 16'd3, {16'd1, 16'd0, 16'd1}, h);
        run("T3 scale 0", 1'b0, 16'd0, {16'd7, 16'd9, 16'd11}, '0);

        h = '0; h[1] = 16'd1;
        run("T4 early", 1'b1, 16'd1, {16'd5, 16'd0, 16'd1}, h);
        t = {16'd5, 16'd0, 16'd1};
        run("T4 full", 1'b0, 16'd1, t, model(1'b0, 16'd1, t));

        t = {16'd65520, 16'd0, 16'd65520};
        run("edge tau 0 and q-1", 1'b0, 16'd65520, t, model(1'b0, 16'd65520, t));

        for (int r = 0; r < 4; r++) begin
            e = r[0];
            s = W'($urandom % Q);
            for (int j = 0; j < 3; j++) t[j] = W'($urandom % Q);
            run("T5 random", e, s, t, model(e, s, t));
        end

        // Abort mid round 2 with en held high through reset.
        @(negedge clk);
        early = 1'b0; scale = 16'd1; tau = {16'd2, 16'd2, 16'd2}; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (33) @(negedge clk);
        rstb = 1'b0; en = 1'b1;
        @(negedge clk);
        check("abort ready", {ready1, ready2, ready4}, 3'b111);
        check("abort chi lanes1", chi1, '0);
        check("abort chi lanes2", chi2, '0);
        check("abort chi lanes4", chi4, '0);
        rstb = 1'b1;
        repeat (40) @(negedge clk);
        check("no done after abort", {dc1, dc2, dc4}, {n_runs, n_runs, n_runs});
        check("idle with en held", {ready1, ready2, ready4}, 3'b111);
        en = 1'b0;
        @(negedge clk);

        // A second rising edge of en while busy must be ignored.
        push({16'd8, 16'd65517, 16'd65517, 16'd2, 16'd65517, 16'd2, 16'd2, 16'd65520});
        @(negedge clk);
        early = 1'b0; scale = 16'd1; tau = {16'd2, 16'd2, 16'd2}; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1; scale = 16'd5; tau = '0;
        @(negedge clk);
        en = 1'b0;
        wait_done("busy start");
        repeat (60) @(negedge clk);
        check("single done for busy start", {dc1, dc2, dc4}, {n_runs, n_runs, n_runs});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
